// File: rtl/memory_cache_pkg.sv
// Shared parameters and FSM encoding for the direct-mapped
// write-through word cache.
package memory_cache_pkg;

    localparam int CACHE_INDEX_BITS = 6;
    localparam int CACHE_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MEM_REQ  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_RESP     = 3'd4
    } state_e;

endpackage

// File: rtl/memory_cache_line_store.sv
// Line storage: valid/tag/data arrays with one synchronous write port,
// one combinational read port and an asynchronous clear of the valid bits.
module cache_line_store
    import memory_cache_pkg::*;
#(
    parameter int INDEX_BITS = CACHE_INDEX_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [29-INDEX_BITS:0] wr_tag_i,
    input  logic [31:0]           wr_data_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [29-INDEX_BITS:0] rd_tag_o,
    output logic [31:0]           rd_data_o
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/memory_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache placed
// between a memory accessor (CPU_*) and MEMORY (MEM_*).
module memory_cache
    import memory_cache_pkg::*;
#(
    parameter int INDEX_BITS = CACHE_INDEX_BITS,
    parameter int CNT_WIDTH  = CACHE_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CPU_ADDR_VALID,
    input  logic [31:0]          CPU_ADDR,
    input  logic                 CPU_DATA_VALID,
    input  logic [31:0]          CPU_DATA,
    output logic                 CPU_READY,
    output logic                 CPU_RECEIVE_VALID,
    output logic [31:0]          CPU_RECEIVE_DATA,
    input  logic                 CPU_RECEIVE_READY,
    output logic                 MEM_SEND_ADDR_VALID,
    output logic [31:0]          MEM_SEND_ADDR,
    output logic                 MEM_SEND_DATA_VALID,
    output logic [31:0]          MEM_SEND_DATA,
    input  logic                 MEM_SEND_READY,
    input  logic                 MEM_RECEIVE_VALID,
    input  logic [31:0]          MEM_RECEIVE_DATA,
    output logic                 MEM_RECEIVE_READY,
    output logic [CNT_WIDTH-1:0] HIT_COUNT,
    output logic [CNT_WIDTH-1:0] MISS_COUNT
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    state_e               state_q, state_d;
    logic [29:0]          waddr_q, waddr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 poke_q, poke_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0] hit_q, hit_d;
    logic [CNT_WIDTH-1:0] miss_q, miss_d;
    logic                 cpu_rdy_q, rvalid_q, mreq_q, mrdy_q;
    logic                 hit_inc, miss_inc;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  st_we;
    logic [31:0]           st_wdata;
    logic                  ln_valid;
    logic [TAG_BITS-1:0]   ln_tag;
    logic [31:0]           ln_data;
    logic                  lookup_hit;
    logic                  cpu_acc, mreq_acc, mrsp_acc, rsp_acc;
    logic                  unused_addr;

    assign unused_addr = ^CPU_ADDR[1:0];

    assign idx        = waddr_q[INDEX_BITS-1:0];
    assign tag        = waddr_q[29:INDEX_BITS];
    assign lookup_hit = ln_valid && (ln_tag == tag);

    assign cpu_acc  = CPU_ADDR_VALID && cpu_rdy_q;
    assign mreq_acc = mreq_q && MEM_SEND_READY;
    assign mrsp_acc = mrdy_q && MEM_RECEIVE_VALID;
    assign rsp_acc  = rvalid_q && CPU_RECEIVE_READY;

    cache_line_store #(
        .INDEX_BITS (INDEX_BITS)
    ) u_store (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .we_i       (st_we),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (st_wdata),
        .rd_idx_i   (idx),
        .rd_valid_o (ln_valid),
        .rd_tag_o   (ln_tag),
        .rd_data_o  (ln_data)
    );

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        poke_d   = poke_q;
        rdata_d  = rdata_q;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        st_we    = 1'b0;
        st_wdata = MEM_RECEIVE_DATA;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_acc) begin
                    waddr_d = CPU_ADDR[31:2];
                    wdata_d = CPU_DATA;
                    poke_d  = CPU_DATA_VALID;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_inc  = lookup_hit;
                miss_inc = !lookup_hit;
                if (lookup_hit && !poke_q) begin
                    rdata_d = ln_data;
                    state_d = S_RESP;
                end else begin
                    // Poke hit refreshes the resident word; misses never allocate.
                    st_we    = lookup_hit;
                    st_wdata = wdata_q;
                    state_d  = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                if (mreq_acc) begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mrsp_acc) begin
                    state_d = S_RESP;
                    if (poke_q) begin
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = MEM_RECEIVE_DATA;
                        st_we   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_acc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        hit_d  = (hit_inc && !(&hit_q))   ? hit_q + CNT_WIDTH'(1)  : hit_q;
        miss_d = (miss_inc && !(&miss_q)) ? miss_q + CNT_WIDTH'(1) : miss_q;
    end

    // Handshake flags are registered from the next state so every output is 0 in reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            waddr_q   <= '0;
            wdata_q   <= '0;
            poke_q    <= 1'b0;
            rdata_q   <= '0;
            hit_q     <= '0;
            miss_q    <= '0;
            cpu_rdy_q <= 1'b0;
            rvalid_q  <= 1'b0;
            mreq_q    <= 1'b0;
            mrdy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            poke_q    <= poke_d;
            rdata_q   <= rdata_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            cpu_rdy_q <= (state_d == S_IDLE);
            rvalid_q  <= (state_d == S_RESP);
            mreq_q    <= (state_d == S_MEM_REQ);
            mrdy_q    <= (state_d == S_MEM_WAIT);
        end
    end

    assign CPU_READY           = cpu_rdy_q;
    assign CPU_RECEIVE_VALID   = rvalid_q;
    assign CPU_RECEIVE_DATA    = rdata_q;
    assign MEM_SEND_ADDR_VALID = mreq_q;
    assign MEM_SEND_ADDR       = {waddr_q, 2'b00};
    assign MEM_SEND_DATA_VALID = mreq_q && poke_q;
    assign MEM_SEND_DATA       = wdata_q;
    assign MEM_RECEIVE_READY   = mrdy_q;
    assign HIT_COUNT           = hit_q;
    assign MISS_COUNT          = miss_q;

endmodule

// File: tb/tb_memory_cache.sv
// Randomised bench for memory_cache: bench-side memory, a transaction-level
// cache/timing model and a per-cycle compare process.
module tb_memory_cache;

    localparam int IB    = 6;
    localparam int CW    = 4;
    localparam int LINES = 1 << IB;
    localparam int CMAX  = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          CPU_ADDR_VALID = 1'b0;
    logic [31:0]   CPU_ADDR = '0;
    logic          CPU_DATA_VALID = 1'b0;
    logic [31:0]   CPU_DATA = '0;
    logic          CPU_READY;
    logic          CPU_RECEIVE_VALID;
    logic [31:0]   CPU_RECEIVE_DATA;
    logic          CPU_RECEIVE_READY = 1'b0;
    logic          MEM_SEND_ADDR_VALID;
    logic [31:0]   MEM_SEND_ADDR;
    logic          MEM_SEND_DATA_VALID;
    logic [31:0]   MEM_SEND_DATA;
    logic          MEM_SEND_READY = 1'b0;
    logic          MEM_RECEIVE_VALID = 1'b0;
    logic [31:0]   MEM_RECEIVE_DATA = '0;
    logic          MEM_RECEIVE_READY;
    logic [CW-1:0] HIT_COUNT;
    logic [CW-1:0] MISS_COUNT;

    memory_cache #(
        .INDEX_BITS (IB),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .CPU_ADDR_VALID      (CPU_ADDR_VALID),
        .CPU_ADDR            (CPU_ADDR),
        .CPU_DATA_VALID      (CPU_DATA_VALID),
        .CPU_DATA            (CPU_DATA),
        .CPU_READY           (CPU_READY),
        .CPU_RECEIVE_VALID   (CPU_RECEIVE_VALID),
        .CPU_RECEIVE_DATA    (CPU_RECEIVE_DATA),
        .CPU_RECEIVE_READY   (CPU_RECEIVE_READY),
        .MEM_SEND_ADDR_VALID (MEM_SEND_ADDR_VALID),
        .MEM_SEND_ADDR       (MEM_SEND_ADDR),
        .MEM_SEND_DATA_VALID (MEM_SEND_DATA_VALID),
        .MEM_SEND_DATA       (MEM_SEND_DATA),
        .MEM_SEND_READY      (MEM_SEND_READY),
        .MEM_RECEIVE_VALID   (MEM_RECEIVE_VALID),
        .MEM_RECEIVE_DATA    (MEM_RECEIVE_DATA),
        .MEM_RECEIVE_READY   (MEM_RECEIVE_READY),
        .HIT_COUNT           (HIT_COUNT),
        .MISS_COUNT          (MISS_COUNT)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int  send_stall = 0;
    int  resp_stall = 0;
    bit  mem_hold   = 1'b0;
    int  mem_reqs   = 0;
    logic [31:0] last_rsp;

    logic [31:0] mem_rsp [logic [29:0]];
    logic [31:0] mem_sh  [logic [29:0]];

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // Memory side: random accept stalls, random latency, word store.
    initial begin : responder
        bit          pend;
        int          lat;
        logic [31:0] rword;
        logic [29:0] w;
        pend = 1'b0;
        lat  = 0;
        rword = '0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                pend = 1'b0;
                MEM_SEND_READY = 1'b0;
                MEM_RECEIVE_VALID = 1'b0;
                MEM_RECEIVE_DATA = '0;
                continue;
            end
            if (send_stall > 0) begin
                MEM_SEND_READY = 1'b0;
                if (MEM_SEND_ADDR_VALID) send_stall--;
            end else begin
                MEM_SEND_READY = ($urandom_range(0, 3) != 0);
            end
            if (pend && !mem_hold && lat == 0) begin
                MEM_RECEIVE_VALID = 1'b1;
                MEM_RECEIVE_DATA  = rword;
            end else begin
                MEM_RECEIVE_VALID = 1'b0;
                MEM_RECEIVE_DATA  = $urandom;
                if (lat > 0) lat--;
            end
            #1;
            if (!RST) continue;
            if (MEM_RECEIVE_VALID && MEM_RECEIVE_READY) pend = 1'b0;
            if (MEM_SEND_ADDR_VALID && MEM_SEND_READY) begin
                w = MEM_SEND_ADDR[31:2];
                mem_reqs++;
                if (MEM_SEND_DATA_VALID) mem_rsp[w] = MEM_SEND_DATA;
                rword = mem_rsp.exists(w) ? mem_rsp[w] : init_word(w);
                pend  = 1'b1;
                lat   = $urandom_range(0, 3);
            end
        end
    end

    // Compare process: transaction-level model of residency, counters and timing.
    initial begin : monitor
        bit          ln_v [LINES];
        logic [29:0] ln_w [LINES];
        int          hit_m, miss_m, dh, dm;
        int          t_idle, t_send, t_wait, t_resp, t_cnt;
        logic [29:0] cur_w;
        bit          cur_poke, hit, seen_high;
        logic [31:0] cur_d, exp_rsp;
        int          ix;
        hit_m = 0; miss_m = 0; dh = 0; dm = 0;
        t_idle = -1; t_send = -1; t_wait = -1; t_resp = -1; t_cnt = -1;
        cur_w = '0; cur_poke = 1'b0; cur_d = '0; exp_rsp = '0; seen_high = 1'b0;
        foreach (ln_v[i]) begin ln_v[i] = 1'b0; ln_w[i] = '0; end
        forever begin
            @(negedge CLK);
            #1;
            cyc++;
            if (!RST) begin
                chk("rst_ready", CPU_READY, 0);
                chk("rst_rvalid", CPU_RECEIVE_VALID, 0);
                chk("rst_rdata", CPU_RECEIVE_DATA, 0);
                chk("rst_mvalid", MEM_SEND_ADDR_VALID, 0);
                chk("rst_maddr", MEM_SEND_ADDR, 0);
                chk("rst_mdvalid", MEM_SEND_DATA_VALID, 0);
                chk("rst_mdata", MEM_SEND_DATA, 0);
                chk("rst_mrdy", MEM_RECEIVE_READY, 0);
                chk("rst_hits", HIT_COUNT, 0);
                chk("rst_miss", MISS_COUNT, 0);
                foreach (ln_v[i]) ln_v[i] = 1'b0;
                hit_m = 0; miss_m = 0;
                t_idle = -1; t_send = -1; t_wait = -1; t_resp = -1; t_cnt = -1;
                seen_high = 1'b0;
                continue;
            end
            if (!seen_high) begin
                seen_high = 1'b1;
                t_idle = cyc + 1;
            end
            if (cyc == t_cnt) begin
                hit_m  = (hit_m + dh > CMAX) ? CMAX : hit_m + dh;
                miss_m = (miss_m + dm > CMAX) ? CMAX : miss_m + dm;
                t_cnt = -1;
            end
            chk("cpu_ready", CPU_READY, (t_idle >= 0 && cyc >= t_idle));
            chk("mem_send_valid", MEM_SEND_ADDR_VALID, (t_send >= 0 && cyc >= t_send));
            chk("mem_recv_ready", MEM_RECEIVE_READY, (t_wait >= 0 && cyc >= t_wait));
            chk("cpu_rsp_valid", CPU_RECEIVE_VALID, (t_resp >= 0 && cyc >= t_resp));
            chk("hit_count", HIT_COUNT, hit_m);
            chk("miss_count", MISS_COUNT, miss_m);
            if (MEM_SEND_ADDR_VALID) begin
                chk("mem_addr", MEM_SEND_ADDR, {cur_w, 2'b00});
                chk("mem_dvalid", MEM_SEND_DATA_VALID, cur_poke);
                if (cur_poke) chk("mem_data", MEM_SEND_DATA, cur_d);
            end
            if (CPU_RECEIVE_VALID) chk("rsp_data", CPU_RECEIVE_DATA, exp_rsp);

            if (CPU_ADDR_VALID && CPU_READY) begin
                cur_w    = CPU_ADDR[31:2];
                cur_poke = CPU_DATA_VALID;
                cur_d    = CPU_DATA;
                ix       = int'(cur_w[IB-1:0]);
                hit      = ln_v[ix] && (ln_w[ix] == cur_w);
                dh       = hit ? 1 : 0;
                dm       = hit ? 0 : 1;
                t_cnt    = cyc + 2;
                t_idle   = -1;
                if (cur_poke) begin
                    mem_sh[cur_w] = cur_d;
                    exp_rsp = cur_d;
                end else begin
                    exp_rsp = mem_sh.exists(cur_w) ? mem_sh[cur_w] : init_word(cur_w);
                end
                if (hit && !cur_poke) t_resp = cyc + 2;
                else t_send = cyc + 2;
            end
            if (MEM_SEND_ADDR_VALID && MEM_SEND_READY) begin
                t_send = -1;
                t_wait = cyc + 1;
            end
            if (MEM_RECEIVE_VALID && MEM_RECEIVE_READY) begin
                t_wait = -1;
                t_resp = cyc + 1;
                if (!cur_poke) begin
                    ix = int'(cur_w[IB-1:0]);
                    ln_v[ix] = 1'b1;
                    ln_w[ix] = cur_w;
                end
            end
            if (CPU_RECEIVE_VALID && CPU_RECEIVE_READY) begin
                t_resp = -1;
                t_idle = cyc + 1;
            end
        end
    end

    task automatic cpu_issue(input logic [31:0] a, input bit poke, input logic [31:0] d);
        int n;
        @(negedge CLK);
        CPU_ADDR_VALID = 1'b1;
        CPU_ADDR       = a;
        CPU_DATA_VALID = poke;
        CPU_DATA       = d;
        for (n = 0; n < 50; n++) begin
            #1;
            if (CPU_READY) break;
            @(negedge CLK);
        end
        if (n == 50) timeout("cpu_accept");
        @(negedge CLK);
        CPU_ADDR_VALID = 1'b0;
        CPU_DATA_VALID = 1'b0;
        CPU_ADDR       = $urandom;
        CPU_DATA       = $urandom;
    endtask

    task automatic cpu_collect();
        int n;
        for (n = 0; n < 200; n++) begin
            if (n > 0) @(negedge CLK);
            if (resp_stall > 0) begin
                CPU_RECEIVE_READY = 1'b0;
                if (CPU_RECEIVE_VALID) resp_stall--;
            end else begin
                CPU_RECEIVE_READY = ($urandom_range(0, 2) != 0);
            end
            #1;
            if (CPU_RECEIVE_VALID && CPU_RECEIVE_READY) begin
                last_rsp = CPU_RECEIVE_DATA;
                break;
            end
        end
        if (n == 200) timeout("cpu_response");
        @(negedge CLK);
        CPU_RECEIVE_READY = 1'b0;
    endtask

    task automatic cpu_req(input logic [31:0] a, input bit poke, input logic [31:0] d);
        cpu_issue(a, poke, d);
        cpu_collect();
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0;
        int n;
        logic [31:0] a;
        last_rsp = '0;
        mem_rsp[30'h10] = 32'hDEAD_BEEF;
        mem_sh[30'h10]  = 32'hDEAD_BEEF;

        repeat (3) @(posedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK); #2;
        chk("ready_before_edge", CPU_READY, 0);
        @(negedge CLK); #2;
        chk("ready_first_edge", CPU_READY, 1);

        r0 = mem_reqs;
        cpu_req(32'h40, 1'b0, 32'h0);
        chk("peek40_miss_data", last_rsp, 32'hDEAD_BEEF);
        chk("peek40_miss_cnt", MISS_COUNT, 1);
        chk("peek40_memreq", mem_reqs - r0, 1);

        r0 = mem_reqs;
        cpu_req(32'h40, 1'b0, 32'h0);
        chk("peek40_hit_data", last_rsp, 32'hDEAD_BEEF);
        chk("peek40_hit_cnt", HIT_COUNT, 1);
        chk("peek40_hit_nomem", mem_reqs - r0, 0);

        r0 = mem_reqs;
        cpu_req(32'h40, 1'b1, 32'h1234_5678);
        chk("poke40_echo", last_rsp, 32'h1234_5678);
        chk("poke40_hit_cnt", HIT_COUNT, 2);
        chk("poke40_memreq", mem_reqs - r0, 1);
        chk("poke40_memword", mem_rsp[30'h10], 32'h1234_5678);
        cpu_req(32'h40, 1'b0, 32'h0);
        chk("peek40_after_poke", last_rsp, 32'h1234_5678);
        chk("peek40_after_poke_cnt", HIT_COUNT, 3);

        r0 = mem_reqs;
        cpu_req(32'h80, 1'b1, 32'hCAFE_F00D);
        chk("poke80_miss_cnt", MISS_COUNT, 2);
        cpu_req(32'h80, 1'b0, 32'h0);
        chk("peek80_noalloc_cnt", MISS_COUNT, 3);
        chk("peek80_data", last_rsp, 32'hCAFE_F00D);
        chk("poke_peek80_memreq", mem_reqs - r0, 2);

        cpu_req(32'h40, 1'b0, 32'h0);
        chk("alias_a_hit", HIT_COUNT, 4);
        cpu_req(32'h40 + (32'd4 << IB), 1'b0, 32'h0);
        chk("alias_b_miss", MISS_COUNT, 4);
        cpu_req(32'h40, 1'b0, 32'h0);
        chk("alias_a_evicted", MISS_COUNT, 5);
        chk("alias_a_data", last_rsp, 32'h1234_5678);

        send_stall = 5;
        resp_stall = 3;
        cpu_req(32'h204, 1'b1, 32'h0BAD_F00D);
        chk("bp_poke_echo", last_rsp, 32'h0BAD_F00D);
        chk("bp_send_stall_used", send_stall, 0);
        chk("bp_resp_stall_used", resp_stall, 0);

        mem_hold = 1'b1;
        cpu_issue(32'h300, 1'b0, 32'h0);
        for (n = 0; n < 50; n++) begin
            @(negedge CLK); #1;
            if (MEM_RECEIVE_READY) break;
        end
        if (n == 50) timeout("reach_mem_wait");
        #1 RST = 1'b0;
        repeat (2) @(negedge CLK);
        mem_hold = 1'b0;
        @(posedge CLK);
        #2 RST = 1'b1;
        cpu_req(32'h40, 1'b0, 32'h0);
        chk("post_rst_miss", MISS_COUNT, 1);
        chk("post_rst_hits", HIT_COUNT, 0);
        chk("post_rst_data", last_rsp, 32'h1234_5678);

        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(0, 3)) << (IB + 2)) |
                (32'($urandom_range(0, 7)) << 2) |
                32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) send_stall = $urandom_range(1, 4);
            if ($urandom_range(0, 15) == 0) resp_stall = $urandom_range(1, 4);
            cpu_req(a, ($urandom_range(0, 9) < 3), $urandom);
        end
        chk("hit_saturated", HIT_COUNT, CMAX);
        chk("miss_saturated", MISS_COUNT, CMAX);

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
